// File: rtl/ahb_uart_tx.sv
// ahb_uart_tx: AHB-Lite slave that queues bytes in a TX FIFO and sends them 8N1 on tx.
// Optional feature macro UART_TX_IRQ_EN adds the irq output and the IRQCTL register at index 3.
`timescale 1ns/1ps
module ahb_uart_tx #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned DIV_RESET  = 868
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  hsel,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [31:0]           hwdata,
   output logic [31:0]           hrdata,
   output logic                  hready,
   output logic                  hresp,
`ifdef UART_TX_IRQ_EN
   output logic                  irq,
`endif
   output logic                  tx
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} txState_t;

   logic             dpValid_q;
   logic             dpWrite_q;
   logic [1:0]       dpAddr_q;
   logic [15:0]      baudDiv_q;
   logic [7:0]       fifoMem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr_q;
   logic [PTR_W-1:0] rdPtr_q;
   logic [CNT_W-1:0] count_q;

   txState_t    state_q, state_d;
   logic [15:0] bitCnt_q, bitCnt_d;
   logic [2:0]  bitIdx_q, bitIdx_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;

   logic        accept;
   logic        fifoFull;
   logic        fifoEmpty;
   logic        dpTxWrite;
   logic        regWrite;
   logic        stall;
   logic        push;
   logic        pop;
   logic        busy;
   logic        bitEnd;
   logic [15:0] effDiv;
   logic [31:0] rdValue;
   logic        unusedBits;

   assign accept     = hsel & htrans[1] & hready;
   assign fifoFull   = (count_q == CNT_W'(FIFO_DEPTH));
   assign fifoEmpty  = (count_q == '0);
   assign dpTxWrite  = dpValid_q & dpWrite_q & (dpAddr_q == 2'd0);
   assign regWrite   = dpValid_q & dpWrite_q;
   // A full-FIFO write is held only until the serialiser frees a slot in the same cycle.
   assign stall      = dpTxWrite & fifoFull & ~pop;
   assign push       = dpTxWrite & ~stall;
   assign hready     = ~stall;
   assign hresp      = 1'b0;
   assign busy       = (state_q != ST_IDLE);
   assign bitEnd     = (bitCnt_q == 16'd0);
   assign effDiv     = (baudDiv_q == 16'd0) ? 16'd1 : baudDiv_q;
   assign tx         = tx_q;
   assign unusedBits = ^{haddr, htrans[0], hsize, hwdata[31:16]};

   always_ff @(posedge CLK) begin
      if (RST) begin
         dpValid_q <= 1'b0;
         dpWrite_q <= 1'b0;
         dpAddr_q  <= 2'd0;
      end else if (hready) begin
         dpValid_q <= accept;
         dpWrite_q <= hwrite;
         dpAddr_q  <= haddr[3:2];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         baudDiv_q <= 16'(DIV_RESET);
      end else if (regWrite && dpAddr_q == 2'd2) begin
         baudDiv_q <= hwdata[15:0];
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         fifoMem_q[wrPtr_q] <= hwdata[7:0];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
         if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
         if (push && !pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         bitCnt_q <= 16'd0;
         bitIdx_q <= 3'd0;
         shift_q  <= 8'd0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         bitCnt_q <= bitCnt_d;
         bitIdx_q <= bitIdx_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end

   // The divisor is sampled at every bit start, so BAUDDIV writes apply at the next bit boundary.
   always_comb begin
      state_d  = state_q;
      bitCnt_d = bitEnd ? 16'd0 : bitCnt_q - 16'd1;
      bitIdx_d = bitIdx_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      pop      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (!fifoEmpty) begin
               pop      = 1'b1;
               state_d  = ST_START;
               bitCnt_d = effDiv - 16'd1;
               shift_d  = fifoMem_q[rdPtr_q];
               tx_d     = 1'b0;
            end
         end
         ST_START: begin
            if (bitEnd) begin
               state_d  = ST_DATA;
               bitCnt_d = effDiv - 16'd1;
               bitIdx_d = 3'd0;
               tx_d     = shift_q[0];
            end
         end
         ST_DATA: begin
            if (bitEnd) begin
               bitCnt_d = effDiv - 16'd1;
               if (bitIdx_q == 3'd7) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bitIdx_d = bitIdx_q + 3'd1;
                  shift_d  = {1'b0, shift_q[7:1]};
                  tx_d     = shift_q[1];
               end
            end
         end
         ST_STOP: begin
            if (bitEnd) begin
               if (!fifoEmpty) begin
                  pop      = 1'b1;
                  state_d  = ST_START;
                  bitCnt_d = effDiv - 16'd1;
                  shift_d  = fifoMem_q[rdPtr_q];
                  tx_d     = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

`ifdef UART_TX_IRQ_EN
   logic [1:0] irqCtl_q;
   logic       irq_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         irqCtl_q <= 2'd0;
         irq_q    <= 1'b0;
      end else begin
         if (regWrite && dpAddr_q == 2'd3) irqCtl_q <= hwdata[1:0];
         irq_q <= (irqCtl_q[0] & fifoEmpty & ~busy) | (irqCtl_q[1] & ~fifoFull);
      end
   end

   assign irq = irq_q;
`endif

   always_comb begin
      rdValue = 32'h0;
      case (dpAddr_q)
         2'd1:    rdValue = {16'h0, 8'(count_q), 5'h0, busy, fifoEmpty, fifoFull};
         2'd2:    rdValue = {16'h0, baudDiv_q};
`ifdef UART_TX_IRQ_EN
         2'd3:    rdValue = {30'h0, irqCtl_q};
`endif
         default: rdValue = 32'h0;
      endcase
   end

   assign hrdata = (dpValid_q & ~dpWrite_q) ? rdValue : 32'h0;

endmodule

// File: tb/tb_ahb_uart_tx.sv
// tb_ahb_uart_tx: drives ahb_uart_tx over AHB-Lite and decodes tx frames against a queue of expected bytes.
// Build with UART_TX_IRQ_EN defined to also exercise the irq output.
`timescale 1ns/1ps
module tb_ahb_uart_tx;
   logic        CLK = 1'b0;
   logic        RST;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;
   logic        tx;
`ifdef UART_TX_IRQ_EN
   logic        irq;
`endif

   int          checks = 0;
   int          failures = 0;
   int          curDiv = 868;
   int          frameCount = 0;
   longint      cycleCount = 0;
   logic [7:0]  expQ [$];
   longint      startTimes [$];

   int          monDiv;
   int          monBad;
   int          monBit;
   logic [7:0]  monRx;
   bit          monAbort;

   ahb_uart_tx #(.ADDR_WIDTH(32), .FIFO_DEPTH(8), .DIV_RESET(868)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .hsel   (hsel),
      .haddr  (haddr),
      .htrans (htrans),
      .hwrite (hwrite),
      .hsize  (hsize),
      .hwdata (hwdata),
      .hrdata (hrdata),
      .hready (hready),
      .hresp  (hresp),
`ifdef UART_TX_IRQ_EN
      .irq    (irq),
`endif
      .tx     (tx)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cycleCount <= cycleCount + 1;

   initial begin
      #900000;
      $display("[TB] FAIL watchdog observed=timeout expected=completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic ahbWrite(input logic [3:0] addr, input logic [31:0] data, output int stallCycles);
      haddr  = {28'h0, addr};
      hwrite = 1'b1;
      hsel   = 1'b1;
      htrans = 2'b10;
      @(posedge CLK); #1;
      hsel   = 1'b0;
      htrans = 2'b00;
      hwdata = data;
      stallCycles = 0;
      while (!hready && stallCycles < 500) begin
         @(posedge CLK); #1;
         stallCycles++;
      end
      if (!hready) checkOutput("hreadyTimeout", 32'(hready), 32'h1);
      @(posedge CLK); #1;
   endtask

   task automatic ahbRead(input logic [3:0] addr, output logic [31:0] data);
      haddr  = {28'h0, addr};
      hwrite = 1'b0;
      hsel   = 1'b1;
      htrans = 2'b10;
      @(posedge CLK); #1;
      hsel   = 1'b0;
      htrans = 2'b00;
      data   = hrdata;
      @(posedge CLK); #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b, output int stallCycles);
      expQ.push_back(b);
      ahbWrite(4'h0, {24'h0, b}, stallCycles);
   endtask

   task automatic setDiv(input int d);
      int st;
      ahbWrite(4'h8, 32'(d), st);
      curDiv = (d == 0) ? 1 : d;
   endtask

   task automatic waitIdle(input int budget);
      logic [31:0] s;
      int n;
      n = 0;
      s = 32'hFFFF_FFFF;
      while (n < budget) begin
         ahbRead(4'h4, s);
         if (s == 32'h2) break;
         n++;
      end
      if (n >= budget) checkOutput("idleTimeout", s, 32'h2);
   endtask

   // Decode each frame from the line: start bit, 8 data bits LSB first, stop bit, each curDiv cycles.
   initial begin : txMonitor
      forever begin
         @(negedge CLK);
         if (RST === 1'b0 && tx === 1'b0) begin
            monDiv   = curDiv;
            monBad   = 0;
            monRx    = 8'h00;
            monAbort = 1'b0;
            startTimes.push_back(cycleCount);
            for (int c = 1; c < 10 * monDiv; c++) begin
               @(negedge CLK);
               if (RST !== 1'b0) begin
                  monAbort = 1'b1;
                  break;
               end
               monBit = c / monDiv;
               if (monBit == 0) begin
                  if (tx !== 1'b0) monBad++;
               end else if (monBit == 9) begin
                  if (tx !== 1'b1) monBad++;
               end else if (c % monDiv == 0) begin
                  monRx[3'(monBit - 1)] = tx;
               end else if (tx !== monRx[3'(monBit - 1)]) begin
                  monBad++;
               end
            end
            if (!monAbort) begin
               frameCount++;
               checkOutput("frameTiming", 32'(monBad), 32'h0);
               if (expQ.size() == 0) begin
                  checkOutput("unexpectedFrame", {24'h0, monRx}, 32'hFFFF_FFFF);
               end else begin
                  checkOutput("frameByte", {24'h0, monRx}, {24'h0, expQ.pop_front()});
               end
            end
         end
      end
   end

   initial begin : mainSeq
      logic [31:0] r;
      int st;
      int stallSum;
      int lowCount;
      int n;
      int d;
      int framesBefore;

      RST    = 1'b1;
      hsel   = 1'b0;
      haddr  = 32'h0;
      htrans = 2'b00;
      hwrite = 1'b0;
      hsize  = 3'b010;
      hwdata = 32'h0;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;

      checkOutput("resetHready", 32'(hready), 32'h1);
      checkOutput("resetHresp", 32'(hresp), 32'h0);
      checkOutput("resetHrdata", hrdata, 32'h0);
      checkOutput("resetTx", 32'(tx), 32'h1);
      ahbRead(4'h4, r);
      checkOutput("resetStatus", r, 32'h0000_0002);
      ahbRead(4'h8, r);
      checkOutput("resetBaudDiv", r, 32'd868);
      checkOutput("hrdataOutsideRead", hrdata, 32'h0);

      // Single 0x55 frame at 4 cycles per bit, start bit one cycle after the pop.
      setDiv(4);
      applyStimulus(8'h55, st);
      @(posedge CLK); #1;
      checkOutput("startBitLatency", 32'(tx), 32'h0);
      waitIdle(400);
      checkOutput("frame55Count", 32'(frameCount), 32'd1);

      // Ten writes at 3 cycles per bit: the first is popped at once, so the tenth finds the FIFO full.
      setDiv(3);
      stallSum = 0;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(8'($urandom), st);
         stallSum += st;
      end
      checkOutput("firstNineNoStall", 32'(stallSum), 32'h0);
      ahbRead(4'h4, r);
      checkOutput("statusFull", r, 32'h0000_0805);
      applyStimulus(8'($urandom), st);
      checkOutput("tenthWriteStalled", 32'(st > 0), 32'h1);
      ahbRead(4'h4, r);
      checkOutput("countAfterStalledPush", r, 32'h0000_0805);
      waitIdle(2000);
      checkOutput("burstDrained", 32'(expQ.size()), 32'h0);

      // Back-to-back frames: the second START follows the first STOP with no gap.
      setDiv(2);
      startTimes.delete();
      applyStimulus(8'hA5, st);
      applyStimulus(8'h3C, st);
      ahbRead(4'h4, r);
      checkOutput("statusOneQueued", r, 32'h0000_0104);
      repeat (25) @(posedge CLK);
      #1;
      ahbRead(4'h4, r);
      checkOutput("statusSecondPopped", r, 32'h0000_0006);
      waitIdle(400);
      checkOutput("b2bFrames", 32'(startTimes.size()), 32'd2);
      if (startTimes.size() == 2) checkOutput("b2bSpacing", 32'(startTimes[1] - startTimes[0]), 32'd20);

      // Reset in the middle of a data bit with three bytes still queued.
      setDiv(4);
      applyStimulus(8'h00, st);
      for (int i = 0; i < 3; i++) applyStimulus(8'($urandom), st);
      repeat (10) @(posedge CLK);
      #1;
      checkOutput("txMidData", 32'(tx), 32'h0);
      RST = 1'b1;
      @(posedge CLK); #1;
      checkOutput("txFirstResetEdge", 32'(tx), 32'h1);
      expQ.delete();
      curDiv = 868;
      @(posedge CLK); #1;
      RST = 1'b0;
      ahbRead(4'h4, r);
      checkOutput("statusAfterReset", r, 32'h0000_0002);
      ahbRead(4'h8, r);
      checkOutput("baudAfterReset", r, 32'd868);
      lowCount = 0;
      repeat (60) begin
         @(posedge CLK); #1;
         if (tx !== 1'b1) lowCount++;
      end
      checkOutput("noFramesAfterReset", 32'(lowCount), 32'h0);

      // Reset while a TXDATA write is stalled on a full FIFO.
      setDiv(4);
      for (int i = 0; i < 9; i++) applyStimulus(8'($urandom), st);
      haddr  = 32'h0;
      hwrite = 1'b1;
      hsel   = 1'b1;
      htrans = 2'b10;
      @(posedge CLK); #1;
      hsel   = 1'b0;
      htrans = 2'b00;
      hwdata = 32'h77;
      checkOutput("stallBeforeReset", 32'(hready), 32'h0);
      RST = 1'b1;
      @(posedge CLK); #1;
      checkOutput("hreadyAfterStallReset", 32'(hready), 32'h1);
      expQ.delete();
      curDiv = 868;
      RST = 1'b0;
      ahbRead(4'h4, r);
      checkOutput("statusAfterStallReset", r, 32'h0000_0002);

      // Random rounds: random divisor (0 acts as 1), random byte bursts, reserved/TXDATA reads.
      for (int round = 0; round < 6; round++) begin
         d = (round == 0) ? 0 : int'($urandom_range(1, 5));
         setDiv(d);
         ahbRead(4'h8, r);
         checkOutput("baudReadback", r, 32'(d));
         n = int'($urandom_range(1, 12));
         for (int i = 0; i < n; i++) applyStimulus(8'($urandom), st);
         ahbRead(4'h0, r);
         checkOutput("txdataReadsZero", r, 32'h0);
`ifndef UART_TX_IRQ_EN
         ahbWrite(4'hC, $urandom, st);
         ahbRead(4'hC, r);
         checkOutput("reservedReadsZero", r, 32'h0);
`endif
         waitIdle(2000);
         checkOutput("roundDrained", 32'(expQ.size()), 32'h0);
      end

`ifdef UART_TX_IRQ_EN
      setDiv(2);
      ahbWrite(4'hC, 32'h1, st);
      ahbRead(4'hC, r);
      checkOutput("irqCtlReadback", r, 32'h1);
      checkOutput("irqIdleEmpty", 32'(irq), 32'h1);
      framesBefore = frameCount;
      applyStimulus(8'hC3, st);
      repeat (3) @(posedge CLK);
      #1;
      checkOutput("irqWhileBusy", 32'(irq), 32'h0);
      n = 0;
      while (irq !== 1'b1 && n < 200) begin
         @(posedge CLK); #1;
         n++;
      end
      checkOutput("irqRose", 32'(irq), 32'h1);
      checkOutput("irqAfterFrame", 32'(frameCount - framesBefore), 32'h1);
      ahbWrite(4'hC, 32'h0, st);
      @(posedge CLK); #1;
      checkOutput("irqDisabled", 32'(irq), 32'h0);
`else
      framesBefore = frameCount;
      checkOutput("framesSeen", 32'(framesBefore > 20), 32'h1);
`endif

      repeat (5) @(posedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
